da_bit_slicer: RTL

- Upstream stage of the distributed-arithmetic FIR datapath.
- Accepts parallel input samples over a valid/ready handshake and keeps the tap delay line.
- Serializes the taps bit-plane by bit-plane, MSB first, into the 4-bit addresses that drive the eight DA partial-product LUTs.
- Emits slice-position strobes and an end-of-sample pulse so the downstream shift-accumulator knows when to subtract the sign slice and when to latch its sum.

---
 rtl/da_pkg.sv | 17 +
 rtl/da_tap_line.sv | 48 ++++
 rtl/da_bit_slicer.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/da_pkg.sv
// Shared constants, FSM encoding and sizing helper for the DA bit slicer.
// Optional output pipeline stage: define DA_ADDR_PIPE_EN.
package da_pkg;

    localparam int DA_DATA_W  = 16;
    localparam int DA_NUM_LUT = 8;
    localparam int DA_LUT_IN  = 4;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    function automatic int da_cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/da_tap_line.sv
// FIR tap delay line with load enable, async clear and bit-plane select.
// Optional output pipeline stage in the top: define DA_ADDR_PIPE_EN.
module da_tap_line
    import da_pkg::*;
#(
    parameter int DATA_W = DA_DATA_W,
    parameter int TAPS   = DA_NUM_LUT * DA_LUT_IN,
    localparam int SEL_W = da_cnt_w(DATA_W)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              load_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic [SEL_W-1:0]  sel_i,
    output logic [TAPS-1:0]   plane_o
);

    logic [DATA_W-1:0] taps_q [TAPS];
    logic [DATA_W-1:0] taps_d [TAPS];

    always_comb begin
        taps_d = taps_q;
        if (load_i) begin
            taps_d[0] = data_i;
            for (int i = 1; i < TAPS; i++) begin
                taps_d[i] = taps_q[i-1];
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            taps_q <= '{default: '0};
        end else if (load_i) begin
            taps_q <= taps_d;
        end
    end

    // Plane comes from the next contents so the first slice can be registered
    // in the same edge that loads the new sample.
    always_comb begin
        plane_o = '0;
        for (int i = 0; i < TAPS; i++) begin
            plane_o[i] = taps_d[i][sel_i];
        end
    end

endmodule

// File: rtl/da_bit_slicer.sv
// DA FIR front end: sample handshake, tap line and MSB-first bit-plane slicer.
// Optional output pipeline stage: define DA_ADDR_PIPE_EN.
module da_bit_slicer
    import da_pkg::*;
#(
    parameter int DATA_W  = DA_DATA_W,
    parameter int NUM_LUT = DA_NUM_LUT,
    parameter int LUT_IN  = DA_LUT_IN
) (
    input  logic                      clk3,
    input  logic                      reset,
    input  logic [DATA_W-1:0]         in_data,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic [NUM_LUT*LUT_IN-1:0] lut_addr,
    output logic                      addr_valid,
    output logic                      slice_first,
    output logic                      slice_last,
    output logic                      sum_latch
);

    localparam int TAPS  = NUM_LUT * LUT_IN;
    localparam int CNT_W = da_cnt_w(DATA_W);
    localparam logic [CNT_W-1:0] K_LAST = CNT_W'(DATA_W - 1);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] k_q, k_d;
    logic [CNT_W-1:0] bit_sel;
    logic             load;
    logic [TAPS-1:0]  plane;

    logic             ready_q, ready_d;
    logic [TAPS-1:0]  addr_q, addr_d;
    logic             valid_q, valid_d;
    logic             first_q, first_d;
    logic             last_q, last_d;
    logic             sum_q, sum_d;

    assign load = (state_q == ST_IDLE) && ready_q && in_valid;

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        unique case (state_q)
            ST_IDLE: begin
                if (load) begin
                    state_d = ST_SHIFT;
                    k_d     = '0;
                end
            end
            ST_SHIFT: begin
                if (k_q == K_LAST) begin
                    state_d = ST_DRAIN;
                end else begin
                    k_d = k_q + CNT_W'(1);
                end
            end
            ST_DRAIN: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    assign bit_sel = K_LAST - k_d;

    da_tap_line #(
        .DATA_W (DATA_W),
        .TAPS   (TAPS)
    ) u_taps (
        .clk_i   (clk3),
        .rst_i   (reset),
        .load_i  (load),
        .data_i  (in_data),
        .sel_i   (bit_sel),
        .plane_o (plane)
    );

    // Outputs are decoded from next state so they toggle only on clk3 edges.
    always_comb begin
        valid_d = (state_d == ST_SHIFT);
        addr_d  = valid_d ? plane : '0;
        first_d = valid_d && (k_d == '0);
        last_d  = valid_d && (k_d == K_LAST);
        sum_d   = (state_d == ST_DRAIN);
        ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk3 or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            k_q     <= '0;
            ready_q <= 1'b0;
            addr_q  <= '0;
            valid_q <= 1'b0;
            first_q <= 1'b0;
            last_q  <= 1'b0;
            sum_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            ready_q <= ready_d;
            addr_q  <= addr_d;
            valid_q <= valid_d;
            first_q <= first_d;
            last_q  <= last_d;
            sum_q   <= sum_d;
        end
    end

    assign in_ready = ready_q;

`ifdef DA_ADDR_PIPE_EN
    logic [TAPS-1:0] addr_p_q;
    logic            valid_p_q;
    logic            first_p_q;
    logic            last_p_q;
    logic            sum_p_q;

    always_ff @(posedge clk3 or posedge reset) begin
        if (reset) begin
            addr_p_q  <= '0;
            valid_p_q <= 1'b0;
            first_p_q <= 1'b0;
            last_p_q  <= 1'b0;
            sum_p_q   <= 1'b0;
        end else begin
            addr_p_q  <= addr_q;
            valid_p_q <= valid_q;
            first_p_q <= first_q;
            last_p_q  <= last_q;
            sum_p_q   <= sum_q;
        end
    end

    assign lut_addr    = addr_p_q;
    assign addr_valid  = valid_p_q;
    assign slice_first = first_p_q;
    assign slice_last  = last_p_q;
    assign sum_latch   = sum_p_q;
`else
    assign lut_addr    = addr_q;
    assign addr_valid  = valid_q;
    assign slice_first = first_q;
    assign slice_last  = last_q;
    assign sum_latch   = sum_q;
`endif

endmodule
